// File: rtl/add_image_deadlock_pkg.sv
`default_nettype none
// ============================================================================
// Module  : add_image_deadlock_pkg
// Purpose : Shared definitions for the dataflow deadlock report controller:
//           FSM state encoding and the timestamp width.
// Revision: 1.0 - initial release
// ============================================================================
package add_image_deadlock_pkg;

  localparam int TS_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WATCH  = 3'd1,
    ST_SCAN   = 3'd2,
    ST_REPORT = 3'd3,
    ST_LOCK   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/add_image_rr_find.sv
`default_nettype none
// ============================================================================
// Module  : add_image_rr_find
// Purpose : Combinational wrapping first-set-bit search. Returns the lowest
//           set bit of vec at or above ptr; if none, wraps to search from 0.
// Ports   : vec   - candidate vector (N bits)
//           ptr   - search start position (W bits, expected < N)
//           idx   - index of the selected bit (0 when none found)
//           found - 1 when vec has any set bit
// Revision: 1.0 - initial release
// ============================================================================
module add_image_rr_find #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  // Two ordered passes: first the upper segment [ptr, N-1], then the wrapped
  // lower segment [0, ptr-1]. The first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && vec[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && vec[i] && (i < int'(ptr))) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/add_image_hls_deadlock_report_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : add_image_hls_deadlock_report_ctrl
// Purpose : Supervises per-process deadlock monitors. Declares a deadlock when
//           some non-idle process stays blocked for PERSIST_CYCLES consecutive
//           cycles, then reports every blocked process index once, in
//           round-robin order, through a valid/ready handshake.
// Ports   : clock, reset (sync, active-high), enable, clear (abandon/end),
//           proc_block/proc_idle (NUM_PROC each), report_ready,
//           deadlock, report_valid, report_idx, report_count, deadlock_cycle.
// Config  : ADD_IMAGE_DEADLOCK_TIMESTAMP_EN - when defined, a free-running
//           cycle counter stamps the detecting edge into deadlock_cycle;
//           otherwise deadlock_cycle is tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
module add_image_hls_deadlock_report_ctrl
  import add_image_deadlock_pkg::*;
#(
  parameter int NUM_PROC       = 4,
  parameter int PERSIST_CYCLES = 16,
  parameter int IDX_W          = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [NUM_PROC-1:0] proc_block,
  input  logic [NUM_PROC-1:0] proc_idle,
  input  logic                report_ready,
  output logic                deadlock,
  output logic                report_valid,
  output logic [IDX_W-1:0]    report_idx,
  output logic [IDX_W-1:0]    report_count,
  output logic [TS_W-1:0]     deadlock_cycle
);

  localparam int CNT_W = 16;

  state_t              state;
  logic [CNT_W-1:0]    persist_cnt;
  logic [NUM_PROC-1:0] pending;
  logic [IDX_W-1:0]    rr_ptr;

  logic [NUM_PROC-1:0] eff;
  logic                detect;
  logic [IDX_W-1:0]    found_idx;
  logic                found;

  // A process that is idle is not considered blocked.
  assign eff = proc_block & ~proc_idle;

  // Edge on which the deadlock is declared (clear has priority).
  assign detect = (state == ST_WATCH) && !clear && enable && (|eff) &&
                  (persist_cnt == CNT_W'(PERSIST_CYCLES));

  add_image_rr_find #(
    .N (NUM_PROC),
    .W (IDX_W)
  ) u_rr_find (
    .vec   (pending),
    .ptr   (rr_ptr),
    .idx   (found_idx),
    .found (found)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      persist_cnt  <= '0;
      pending      <= '0;
      rr_ptr       <= '0;
      deadlock     <= 1'b0;
      report_valid <= 1'b0;
      report_idx   <= '0;
      report_count <= '0;
    end else if (clear) begin
      // report_count and rr_ptr survive a clear so the next sequence continues
      // round-robin where this one stopped.
      state        <= ST_IDLE;
      persist_cnt  <= '0;
      pending      <= '0;
      deadlock     <= 1'b0;
      report_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && (|eff)) begin
            state       <= ST_WATCH;
            persist_cnt <= CNT_W'(1);
          end
        end
        ST_WATCH: begin
          if (!enable || !(|eff)) begin
            state       <= ST_IDLE;
            persist_cnt <= '0;
          end else if (detect) begin
            state        <= ST_SCAN;
            pending      <= eff;
            deadlock     <= 1'b1;
            report_count <= '0;
          end else begin
            persist_cnt <= persist_cnt + CNT_W'(1);
          end
        end
        ST_SCAN: begin
          if (found) begin
            state        <= ST_REPORT;
            report_idx   <= found_idx;
            report_valid <= 1'b1;
          end else begin
            state <= ST_LOCK;
          end
        end
        ST_REPORT: begin
          if (report_ready) begin
            state        <= ST_SCAN;
            report_valid <= 1'b0;
            pending      <= pending & ~(NUM_PROC'(1) << report_idx);
            rr_ptr       <= (report_idx == IDX_W'(NUM_PROC - 1)) ? '0
                                                                 : report_idx + IDX_W'(1);
            if (report_count != {IDX_W{1'b1}}) begin
              report_count <= report_count + IDX_W'(1);
            end
          end
        end
        ST_LOCK: begin
          state <= ST_LOCK;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ADD_IMAGE_DEADLOCK_TIMESTAMP_EN
  // cycle_cnt holds the number of edges seen since reset was released, so the
  // stamp taken on a detecting edge is that edge's ordinal (first edge = 1).
  logic [TS_W-1:0] cycle_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt      <= '0;
      deadlock_cycle <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + TS_W'(1);
      if (detect) begin
        deadlock_cycle <= cycle_cnt + TS_W'(1);
      end
    end
  end
`else
  assign deadlock_cycle = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_image_hls_deadlock_report_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_image_hls_deadlock_report_ctrl
// Purpose : Directed, table-driven bench for the deadlock report controller
//           (NUM_PROC=4, PERSIST_CYCLES=16) plus a timestamp sequence.
// Revision: 1.0 - initial release
// ============================================================================
module tb_add_image_hls_deadlock_report_ctrl;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [3:0]  proc_block;
  logic [3:0]  proc_idle;
  logic        report_ready;
  logic        deadlock;
  logic        report_valid;
  logic [3:0]  report_idx;
  logic [3:0]  report_count;
  logic [31:0] deadlock_cycle;

  int n_checks = 0;
  int n_fail   = 0;

  add_image_hls_deadlock_report_ctrl #(
    .NUM_PROC       (4),
    .PERSIST_CYCLES (16),
    .IDX_W          (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .clear          (clear),
    .proc_block     (proc_block),
    .proc_idle      (proc_idle),
    .report_ready   (report_ready),
    .deadlock       (deadlock),
    .report_valid   (report_valid),
    .report_idx     (report_idx),
    .report_count   (report_count),
    .deadlock_cycle (deadlock_cycle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       en;
    logic       rdy;
    logic [3:0] blk;
    logic [3:0] idl;
    int         n;
    logic       e_dl;
    logic       e_v;
    logic [3:0] e_idx;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic clr, input logic en, input logic rdy,
                     input logic [3:0] blk, input logic [3:0] idl, input int n,
                     input logic e_dl, input logic e_v, input logic [3:0] e_idx,
                     input logic [3:0] e_cnt);
    vec_t v;
    v = '{rst, clr, en, rdy, blk, idl, n, e_dl, e_v, e_idx, e_cnt};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  logic [31:0] exp_ts;

  initial begin
    reset        = 1'b1;
    clear        = 1'b0;
    enable       = 1'b0;
    report_ready = 1'b0;
    proc_block   = 4'b0000;
    proc_idle    = 4'b0000;

    //   rst clr en rdy  blk      idl     n   dl v  idx    cnt
    add(1, 0, 0, 0, 4'b0000, 4'b0000,  2, 0, 0, 4'd0, 4'd0); // reset state
    add(0, 0, 1, 0, 4'b0100, 4'b0000, 16, 0, 0, 4'd0, 4'd0); // 16 blocked cycles
    add(0, 0, 1, 0, 4'b0000, 4'b0000,  1, 0, 0, 4'd0, 4'd0); // drops before persist
    add(0, 0, 1, 1, 4'b1010, 4'b0000, 16, 0, 0, 4'd0, 4'd0); // counter restarted
    add(0, 0, 1, 1, 4'b1010, 4'b0000,  1, 1, 0, 4'd0, 4'd0); // detection on 17th
    add(0, 0, 1, 1, 4'b1010, 4'b0000,  1, 1, 1, 4'd1, 4'd0); // scan -> idx 1
    add(0, 0, 1, 1, 4'b1010, 4'b0000,  1, 1, 0, 4'd1, 4'd1); // accepted
    add(0, 0, 1, 1, 4'b1010, 4'b0000,  1, 1, 1, 4'd3, 4'd1); // scan -> idx 3
    add(0, 0, 1, 1, 4'b1010, 4'b0000,  1, 1, 0, 4'd3, 4'd2); // accepted
    add(0, 0, 1, 1, 4'b1010, 4'b0000,  1, 1, 0, 4'd3, 4'd2); // empty -> LOCK
    add(0, 0, 0, 1, 4'b1111, 4'b0000,  5, 1, 0, 4'd3, 4'd2); // LOCK ignores inputs
    add(0, 1, 0, 0, 4'b0000, 4'b0000,  1, 0, 0, 4'd3, 4'd2); // clear keeps count
    add(0, 0, 1, 1, 4'b0010, 4'b0000, 17, 1, 0, 4'd3, 4'd0); // detect, count reset
    add(0, 0, 1, 1, 4'b0010, 4'b0000,  1, 1, 1, 4'd1, 4'd0); // idx 1
    add(0, 0, 1, 1, 4'b0010, 4'b0000,  1, 1, 0, 4'd1, 4'd1); // rr_ptr becomes 2
    add(0, 0, 1, 1, 4'b0010, 4'b0000,  1, 1, 0, 4'd1, 4'd1); // LOCK
    add(0, 1, 0, 0, 4'b0000, 4'b0000,  1, 0, 0, 4'd1, 4'd1); // clear
    add(0, 0, 1, 0, 4'b0011, 4'b0000, 17, 1, 0, 4'd1, 4'd0); // detect 0011
    add(0, 0, 1, 0, 4'b0011, 4'b0000,  1, 1, 1, 4'd0, 4'd0); // wrap from 2 -> idx 0
    add(0, 0, 0, 0, 4'b0000, 4'b0000,  3, 1, 1, 4'd0, 4'd0); // held, enable ignored
    add(0, 0, 0, 1, 4'b0000, 4'b0000,  1, 1, 0, 4'd0, 4'd1); // accepted
    add(0, 0, 0, 0, 4'b0000, 4'b0000,  1, 1, 1, 4'd1, 4'd1); // snapshot kept: idx 1
    add(0, 1, 0, 0, 4'b0000, 4'b0000,  1, 0, 0, 4'd1, 4'd1); // clear mid-REPORT
    add(0, 0, 0, 0, 4'b0000, 4'b0000,  1, 0, 0, 4'd1, 4'd1); // stays idle
    add(0, 0, 1, 0, 4'b1111, 4'b1111, 40, 0, 0, 4'd1, 4'd1); // idle masking
    add(0, 0, 0, 0, 4'b1111, 4'b0000, 20, 0, 0, 4'd1, 4'd1); // enable off
    add(0, 0, 1, 0, 4'b1000, 4'b0000, 10, 0, 0, 4'd1, 4'd1); // into WATCH
    add(0, 0, 1, 0, 4'b1000, 4'b0000,  1, 0, 0, 4'd0, 4'd0); // reset row, rst set below
    add(0, 0, 1, 0, 4'b1000, 4'b0000, 16, 0, 0, 4'd0, 4'd0); // full persist restarts
    add(0, 0, 1, 0, 4'b1000, 4'b0000,  1, 1, 0, 4'd0, 4'd0); // detection
    tbl[27].rst = 1'b1; // reset mid-WATCH with clear-free stimulus

    #1;
    for (int r = 0; r < tbl.size(); r++) begin
      reset        = tbl[r].rst;
      clear        = tbl[r].clr;
      enable       = tbl[r].en;
      report_ready = tbl[r].rdy;
      proc_block   = tbl[r].blk;
      proc_idle    = tbl[r].idl;
      repeat (tbl[r].n) @(posedge clock);
      #1;
      chk("deadlock",     r, 32'(deadlock),     32'(tbl[r].e_dl));
      chk("report_valid", r, 32'(report_valid), 32'(tbl[r].e_v));
      chk("report_idx",   r, 32'(report_idx),   32'(tbl[r].e_idx));
      chk("report_count", r, 32'(report_count), 32'(tbl[r].e_cnt));
`ifndef ADD_IMAGE_DEADLOCK_TIMESTAMP_EN
      chk("deadlock_cycle", r, deadlock_cycle, 32'd0);
`endif
    end

    // Timestamp sequence: detection lands on the 100th edge after reset.
`ifdef ADD_IMAGE_DEADLOCK_TIMESTAMP_EN
    exp_ts = 32'd100;
`else
    exp_ts = 32'd0;
`endif
    reset      = 1'b1;
    clear      = 1'b0;
    enable     = 1'b1;
    proc_block = 4'b0000;
    proc_idle  = 4'b0000;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("ts_after_reset", 0, deadlock_cycle, 32'd0);
    repeat (83) @(posedge clock);
    #1;
    proc_block = 4'b0001;
    repeat (16) @(posedge clock);
    #1;
    chk("ts_deadlock_edge99", 99, 32'(deadlock), 32'd0);
    @(posedge clock);
    #1;
    chk("ts_deadlock_edge100", 100, 32'(deadlock), 32'd1);
    chk("ts_deadlock_cycle", 100, deadlock_cycle, exp_ts);
    proc_block = 4'b0000;
    clear      = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    chk("ts_held_after_clear", 101, deadlock_cycle, exp_ts);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
